// File: rtl/pulp_cg_ctrl.sv
// Clock-gate enable controller driving a pulp_clock_gating ICG.
// Runs idle detection, quiesce handshake, gating and timed wake-up.
module pulp_cg_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  input  logic             busy_i,
  input  logic             wake_i,
  output logic             qreq_o,
  input  logic             qack_i,
  input  logic             test_en_i,
  output logic             cg_en_o,
  output logic             cg_test_en_o,
  output logic             gated_o,
  output logic [2:0]       state_o
);

  localparam int unsigned WK_W =
    (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WK_W-1:0] WK_LOAD =
    WK_W'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    QREQ    = 3'd1,
    GATED   = 3'd2,
    WAKE    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WK_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic             cg_en_q, cg_en_d;
  logic             qreq_q, qreq_d;
  logic             gated_q, gated_d;

  logic             idle;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thr_eff;
  logic             thr_hit;
  logic             abort;

  assign idle    = !busy_i && !wake_i && enable_i;
  assign cnt_inc = {1'b0, idle_cnt_q} + 1'b1;
  assign thr_eff = (idle_thresh_i == '0) ?
                   (CNT_W+1)'(1) :
                   {1'b0, idle_thresh_i};
  assign thr_hit = cnt_inc >= thr_eff;
  assign abort   = wake_i || busy_i || !enable_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (thr_hit) begin
          idle_cnt_d = '0;
          state_d    = QREQ;
        end else if (!(&idle_cnt_q)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      QREQ: begin
        // abort beats a simultaneous acknowledge
        if (abort) begin
          state_d = RELEASE;
        end else if (qack_i) begin
          state_d = GATED;
        end
      end
      GATED: begin
        if (wake_i || !enable_i) begin
          state_d    = WAKE;
          wake_cnt_d = WK_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (!qack_i) begin
          state_d    = ACTIVE;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ACTIVE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  // outputs registered from next state so they track state_q exactly
  always_comb begin
    cg_en_d = (state_d != GATED);
    gated_d = (state_d == GATED);
    qreq_d  = (state_d == QREQ) ||
              (state_d == GATED) ||
              (state_d == WAKE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      cg_en_q    <= 1'b1;
      qreq_q     <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      cg_en_q    <= cg_en_d;
      qreq_q     <= qreq_d;
      gated_q    <= gated_d;
    end
  end

  assign cg_en_o      = cg_en_q;
  assign qreq_o       = qreq_q;
  assign gated_o      = gated_q;
  assign state_o      = state_q;
  assign cg_test_en_o = test_en_i;

endmodule

// File: tb/tb_pulp_cg_ctrl.sv
// Directed bench for pulp_cg_ctrl.
// Hand-computed expectations per step, checked 1ns after each edge.
module tb_pulp_cg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] thresh;
  logic       busy;
  logic       wake;
  logic       qreq;
  logic       qack;
  logic       test_en;
  logic       cg_en;
  logic       cg_test_en;
  logic       gated;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulp_cg_ctrl #(.CNT_W(8), .WAKE_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .idle_thresh_i(thresh),
    .busy_i       (busy),
    .wake_i       (wake),
    .qreq_o       (qreq),
    .qack_i       (qack),
    .test_en_i    (test_en),
    .cg_en_o      (cg_en),
    .cg_test_en_o (cg_test_en),
    .gated_o      (gated),
    .state_o      (state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] st,
                         input logic en,
                         input logic rq,
                         input logic gt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".cg_en"}, 32'(cg_en), 32'(en));
    chk({tag, ".qreq"},  32'(qreq),  32'(rq));
    chk({tag, ".gated"}, 32'(gated), 32'(gt));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; thresh = 8'd5;
    busy = 1'b0; wake = 1'b0; qack = 1'b0;
    test_en = 1'b0;
    step();
    chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // thresh=5: QREQ on the fifth idle edge, not earlier
    for (int i = 0; i < 4; i++) step();
    chk_all("idle4", 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("idle5", 3'd1, 1'b1, 1'b1, 1'b0);
    qack = 1'b1;
    step();
    chk_all("gate", 3'd2, 1'b0, 1'b1, 1'b1);
    busy = 1'b1;
    step();
    chk_all("gate_busy", 3'd2, 1'b0, 1'b1, 1'b1);
    busy = 1'b0;

    // wake pulse: four WAKE cycles with qreq held
    wake = 1'b1;
    step();
    chk_all("wake1", 3'd3, 1'b1, 1'b1, 1'b0);
    wake = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("wakeN", 3'd3, 1'b1, 1'b1, 1'b0);
    end
    step();
    chk_all("rel", 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rel_hold", 3'd4, 1'b1, 1'b0, 1'b0);
    qack = 1'b0;
    busy = 1'b1;
    step();
    chk_all("rel_done", 3'd0, 1'b1, 1'b0, 1'b0);

    // abort beats qack in QREQ
    thresh = 8'd1;
    busy = 1'b0;
    step();
    chk_all("q_thr1", 3'd1, 1'b1, 1'b1, 1'b0);
    wake = 1'b1; qack = 1'b1;
    step();
    chk_all("abort", 3'd4, 1'b1, 1'b0, 1'b0);
    wake = 1'b0; qack = 1'b0; busy = 1'b1;
    step();
    chk_all("abort_done", 3'd0, 1'b1, 1'b0, 1'b0);

    // thresh=3 with busy at idle cycle 2 restarts the count
    thresh = 8'd3;
    busy = 1'b0;
    step();
    busy = 1'b1;
    step();
    busy = 1'b0;
    step();
    step();
    chk_all("restart2", 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("restart3", 3'd1, 1'b1, 1'b1, 1'b0);
    busy = 1'b1;
    step();
    chk_all("busy_abort", 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("busy_back", 3'd0, 1'b1, 1'b0, 1'b0);

    // thresh=0 behaves as 1; enable_i=0 wakes from GATED
    thresh = 8'd0;
    busy = 1'b0;
    step();
    chk_all("thr0", 3'd1, 1'b1, 1'b1, 1'b0);
    qack = 1'b1;
    step();
    chk_all("gate2", 3'd2, 1'b0, 1'b1, 1'b1);
    enable = 1'b0;
    step();
    chk_all("en_wake", 3'd3, 1'b1, 1'b1, 1'b0);
    enable = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk_all("rst_wake", 3'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // gate again, then reset while GATED
    step();
    chk_all("q3", 3'd1, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("gate3", 3'd2, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk_all("rst_gated", 3'd0, 1'b1, 1'b0, 1'b0);

    // scan enable passes straight through
    test_en = 1'b1;
    #1;
    chk("test_en1", 32'(cg_test_en), 32'd1);
    test_en = 1'b0;
    #1;
    chk("test_en0", 32'(cg_test_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
